// File: rtl/bt_pkg.sv
// Shared command byte values and handshake FSM encoding for the Bluetooth
// command path.
package bt_pkg;

   localparam logic [7:0] CMD_UP   = 8'h41;
   localparam logic [7:0] CMD_DOWN = 8'h42;
   localparam logic [7:0] CMD_STOP = 8'h43;
   localparam logic [7:0] CMD_LON  = 8'h4A;
   localparam logic [7:0] CMD_LOFF = 8'h4B;
   localparam logic [7:0] NACK     = 8'h3F;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACK_WAIT,
      ACK_SEND,
      ACK_HOLD
   } state_t;

endpackage

// File: rtl/motor_guard.sv
// Motor direction register with reversal dead-time and a no-command watchdog.
// A non-zero dt counter means a reversal is in progress and pend_up is valid.
module motor_guard #(
   parameter int unsigned WDOG_CYCLES = 50000000,
   parameter int unsigned DEADTIME    = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic up,
   input  logic down,
   input  logic stop,
   output logic izq,
   output logic der
);

   localparam int unsigned DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
   localparam int unsigned WW = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
   localparam logic [DW-1:0] DT_LOAD = DW'(DEADTIME);
   localparam logic [WW-1:0] WD_LOAD = WW'(WDOG_CYCLES);

   logic [DW-1:0] dt;
   logic [WW-1:0] wd;
   logic          pend_up;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         izq     <= 1'b0;
         der     <= 1'b0;
         pend_up <= 1'b0;
         dt      <= '0;
         wd      <= '0;
      end else if (stop) begin
         izq <= 1'b0;
         der <= 1'b0;
         dt  <= '0;
         wd  <= WD_LOAD;
      end else if (up || down) begin
         wd <= WD_LOAD;
         if (dt != '0) begin
            // A command landing on the expiry cycle takes effect directly.
            if (dt == DW'(1)) begin
               der <= up;
               izq <= down;
               dt  <= '0;
            end else begin
               pend_up <= up;
               dt      <= dt - DW'(1);
            end
         end else if ((der && down) || (izq && up)) begin
            if (DEADTIME == 0) begin
               der <= up;
               izq <= down;
            end else begin
               der     <= 1'b0;
               izq     <= 1'b0;
               pend_up <= up;
               dt      <= DT_LOAD;
            end
         end else begin
            der <= up;
            izq <= down;
         end
      end else if (dt != '0) begin
         if (dt == DW'(1)) begin
            der <= pend_up;
            izq <= !pend_up;
         end
         dt <= dt - DW'(1);
      end else if (izq || der) begin
         if (wd == WW'(1)) begin
            izq <= 1'b0;
            der <= 1'b0;
         end
         if (wd != '0) wd <= wd - WW'(1);
      end
   end

endmodule

// File: rtl/bt_cmd_decoder.sv
// Consumes receiver bytes, decodes motor/lamp commands and echoes ack/nack
// bytes through the transmitter.
module bt_cmd_decoder
   import bt_pkg::*;
#(
   parameter int unsigned WDOG_CYCLES = 50000000,
   parameter int unsigned DEADTIME    = 5000000,
   parameter bit          ECHO_EN     = 1'b1
) (
   input  logic       clk_50m,
   input  logic       rst,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   output logic       rx_rdy_clr,
   input  logic       tx_busy,
   output logic [7:0] tx_din,
   output logic       tx_wr_en,
   output logic       izq,
   output logic       der,
   output logic       on_off_l,
   output logic       cmd_err,
   output logic [7:0] last_cmd
);

   state_t     state, state_next;
   logic [7:0] byte_q;
   logic       new_byte;
   logic [1:0] hold_cnt;
   logic       byte_valid;

   assign byte_valid = (byte_q == CMD_UP) || (byte_q == CMD_DOWN) || (byte_q == CMD_STOP) ||
                       (byte_q == CMD_LON) || (byte_q == CMD_LOFF);

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:     if (rx_rdy) state_next = CLEAR;
         CLEAR:    if (!rx_rdy) state_next = ECHO_EN ? ACK_WAIT : IDLE;
         ACK_WAIT: if (!tx_busy) state_next = ACK_SEND;
         ACK_SEND: state_next = ACK_HOLD;
         ACK_HOLD: if (tx_busy || hold_cnt == 2'd3) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      rx_rdy_clr = (state == CLEAR);
      tx_wr_en   = (state == ACK_SEND);
      tx_din     = '0;
      if (state == ACK_SEND) tx_din = byte_valid ? byte_q : NACK;
   end

   // new_byte marks the single decode cycle, one edge after the byte is latched.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         byte_q   <= '0;
         new_byte <= 1'b0;
         hold_cnt <= '0;
         cmd_err  <= 1'b0;
         last_cmd <= '0;
         on_off_l <= 1'b0;
      end else begin
         new_byte <= (state == IDLE) && rx_rdy;
         if ((state == IDLE) && rx_rdy) byte_q <= rx_data;
         hold_cnt <= (state == ACK_HOLD) ? hold_cnt + 2'd1 : 2'd0;
         cmd_err  <= new_byte && !byte_valid;
         if (new_byte && byte_valid) last_cmd <= byte_q;
         if (new_byte && byte_q == CMD_LON)  on_off_l <= 1'b1;
         if (new_byte && byte_q == CMD_LOFF) on_off_l <= 1'b0;
      end
   end

   motor_guard #(
      .WDOG_CYCLES(WDOG_CYCLES),
      .DEADTIME   (DEADTIME)
   ) u_motor_guard (
      .clk (clk_50m),
      .rst (rst),
      .up  (new_byte && byte_q == CMD_UP),
      .down(new_byte && byte_q == CMD_DOWN),
      .stop(new_byte && byte_q == CMD_STOP),
      .izq (izq),
      .der (der)
   );

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// Bench for bt_cmd_decoder: directed scenarios plus random command traffic,
// checked every cycle against a deadline-based behavioural model.
module tb_bt_cmd_decoder;

   localparam int WD  = 20;
   localparam int DT  = 10;
   localparam int GAP = 8;

   logic       clk_50m = 1'b0;
   logic       rst;
   logic       rx_rdy;
   logic [7:0] rx_data;
   logic       rx_rdy_clr;
   logic       tx_busy;
   logic [7:0] tx_din;
   logic       tx_wr_en;
   logic       izq, der, on_off_l, cmd_err;
   logic [7:0] last_cmd;

   bt_cmd_decoder #(
      .WDOG_CYCLES(WD),
      .DEADTIME   (DT),
      .ECHO_EN    (1'b1)
   ) dut (
      .clk_50m   (clk_50m),
      .rst       (rst),
      .rx_rdy    (rx_rdy),
      .rx_data   (rx_data),
      .rx_rdy_clr(rx_rdy_clr),
      .tx_busy   (tx_busy),
      .tx_din    (tx_din),
      .tx_wr_en  (tx_wr_en),
      .izq       (izq),
      .der       (der),
      .on_off_l  (on_off_l),
      .cmd_err   (cmd_err),
      .last_cmd  (last_cmd)
   );

   always #10 clk_50m = ~clk_50m;

   typedef struct {
      int         c;
      logic [7:0] b;
   } ev_t;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   bit auto_clr = 1'b1;

   // Model: motor direction (0 stop, 1 up, 2 down) with absolute deadlines.
   int         cur, pend, dt_end, wd_end;
   bit         lamp, err_exp, exp_wr;
   logic [7:0] last, exp_din;
   ev_t        dec_q[$];
   ev_t        snd_q[$];

   function automatic bit is_valid(input logic [7:0] b);
      return b inside {8'h41, 8'h42, 8'h43, 8'h4A, 8'h4B};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp_v);
   endtask

   task automatic model_reset();
      cur = 0; pend = 0; dt_end = 0; wd_end = 0;
      lamp = 0; err_exp = 0; exp_wr = 0; last = 8'h00; exp_din = 8'h00;
      dec_q.delete();
      snd_q.delete();
   endtask

   task automatic apply_cmd(input logic [7:0] b, input int t);
      int d;
      if (is_valid(b)) last = b;
      else err_exp = 1;
      if (b == 8'h4A) lamp = 1;
      if (b == 8'h4B) lamp = 0;
      if (b == 8'h43) begin
         cur = 0;
         pend = 0;
      end
      if (b == 8'h41 || b == 8'h42) begin
         d = (b == 8'h41) ? 1 : 2;
         if (pend != 0) pend = d;
         else if (cur == 0) begin
            cur = d;
            wd_end = t + WD;
         end else if (cur == d) wd_end = t + WD;
         else begin
            cur = 0;
            pend = d;
            dt_end = t + DT;
         end
      end
   endtask

   task automatic model_edge();
      ev_t e;
      err_exp = 0;
      exp_wr = 0;
      exp_din = 8'h00;
      if (dec_q.size() > 0 && dec_q[0].c == cyc) begin
         e = dec_q.pop_front();
         apply_cmd(e.b, cyc);
      end
      if (pend != 0 && cyc == dt_end) begin
         cur = pend;
         pend = 0;
         wd_end = cyc + WD;
      end
      if (cur != 0 && cyc == wd_end) cur = 0;
      if (snd_q.size() > 0 && snd_q[0].c == cyc) begin
         e = snd_q.pop_front();
         exp_wr = 1;
         exp_din = is_valid(e.b) ? e.b : 8'h3F;
      end
   endtask

   task automatic step();
      @(posedge clk_50m);
      cyc++;
      model_edge();
      #1;
      if (auto_clr && rx_rdy_clr) rx_rdy = 1'b0;
      check("izq", izq, (cur == 2) ? 8'd1 : 8'd0);
      check("der", der, (cur == 1) ? 8'd1 : 8'd0);
      check("exclusive", izq & der, 8'd0);
      check("on_off_l", on_off_l, lamp);
      check("last_cmd", last_cmd, last);
      check("cmd_err", cmd_err, err_exp);
      check("tx_wr_en", tx_wr_en, exp_wr);
      if (exp_wr) check("tx_din", tx_din, exp_din);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Present a byte right after an edge; the DUT samples it on the next edge.
   task automatic send_byte(input logic [7:0] b, input bit echo_now);
      rx_data = b;
      rx_rdy = 1'b1;
      dec_q.push_back('{c: cyc + 2, b: b});
      if (echo_now) snd_q.push_back('{c: cyc + 3, b: b});
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_izq"}, izq, 8'd0);
      check({tag, "_der"}, der, 8'd0);
      check({tag, "_lamp"}, on_off_l, 8'd0);
      check({tag, "_err"}, cmd_err, 8'd0);
      check({tag, "_last"}, last_cmd, 8'd0);
      check({tag, "_clr"}, rx_rdy_clr, 8'd0);
      check({tag, "_wr"}, tx_wr_en, 8'd0);
      check({tag, "_din"}, tx_din, 8'd0);
   endtask

   initial begin
      int c0;
      logic [7:0] b;
      rst = 1'b1;
      rx_rdy = 1'b0;
      rx_data = 8'h00;
      tx_busy = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_50m);
      #1;
      check_zero("reset");
      rst = 1'b0;
      idle(2);

      // Slow receiver: clear stays high until rdy drops, then one echo pulse.
      auto_clr = 1'b0;
      c0 = cyc;
      send_byte(8'h41, 1'b0);
      snd_q.push_back('{c: c0 + 4, b: 8'h41});
      step();
      check("clr_hi1", rx_rdy_clr, 8'd1);
      step();
      check("clr_hi2", rx_rdy_clr, 8'd1);
      rx_rdy = 1'b0;
      step();
      check("clr_lo", rx_rdy_clr, 8'd0);
      auto_clr = 1'b1;
      idle(10);

      // Reversal dead-time, then a mid-dead-time re-target.
      send_byte(8'h41, 1'b1); idle(12);
      send_byte(8'h42, 1'b1); idle(25);
      send_byte(8'h41, 1'b1); idle(GAP);
      send_byte(8'h42, 1'b1); idle(GAP);
      send_byte(8'h41, 1'b1); idle(30);

      // Watchdog with lamp on, then an unrecognised byte.
      send_byte(8'h4A, 1'b1); idle(GAP);
      send_byte(8'h42, 1'b1); idle(30);
      send_byte(8'h5A, 1'b1); idle(10);

      // Transmitter busy: ack stalls, a queued byte follows once back in IDLE.
      tx_busy = 1'b1;
      c0 = cyc;
      send_byte(8'h4B, 1'b0);
      idle(5);
      rx_data = 8'h41;
      rx_rdy = 1'b1;
      idle(95);
      tx_busy = 1'b0;
      c0 = cyc;
      snd_q.push_back('{c: c0 + 1, b: 8'h4B});
      dec_q.push_back('{c: c0 + 8, b: 8'h41});
      snd_q.push_back('{c: c0 + 9, b: 8'h41});
      idle(35);

      // Reset while waiting for the transmitter.
      send_byte(8'h4A, 1'b1); idle(GAP);
      tx_busy = 1'b1;
      send_byte(8'h43, 1'b0); idle(4);
      rst = 1'b1;
      #1;
      check_zero("rst_ackwait");
      model_reset();
      idle(2);
      rst = 1'b0;
      tx_busy = 1'b0;
      idle(15);

      // Reset in the middle of a dead-time.
      send_byte(8'h41, 1'b1); idle(GAP);
      send_byte(8'h42, 1'b1); idle(4);
      rst = 1'b1;
      #1;
      check_zero("rst_dead");
      model_reset();
      idle(2);
      rst = 1'b0;
      idle(20);

      // Random command traffic.
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: b = 8'h41;
            3, 4, 5: b = 8'h42;
            6:       b = 8'h43;
            7:       b = 8'h4A;
            8:       b = 8'h4B;
            default: begin
               b = 8'($urandom_range(0, 255));
               while (is_valid(b)) b = 8'($urandom_range(0, 255));
            end
         endcase
         send_byte(b, 1'b1);
         idle($urandom_range(GAP, 28));
      end
      idle(40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
